// File: rtl/fsm_cu_pkg.sv
// Shared types and constants for the calculator control unit: state codes, ALU ops,
// register addresses, mux selects and the packed control word.
package fsm_cu_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b000,
    S_LOADA = 3'b001,
    S_LOADB = 3'b010,
    S_WAIT  = 3'b011,
    S_EXEC  = 3'b100,
    S_DISP  = 3'b101
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  localparam logic [1:0] R0 = 2'b00;
  localparam logic [1:0] R1 = 2'b01;
  localparam logic [1:0] R2 = 2'b10;
  localparam logic [1:0] R3 = 2'b11;

  localparam logic [1:0] SEL1_ALU  = 2'b00;
  localparam logic [1:0] SEL1_HOLD = 2'b01;
  localparam logic [1:0] SEL1_IN_B = 2'b10;
  localparam logic [1:0] SEL1_IN_A = 2'b11;

  localparam logic SEL2_PASS   = 1'b0;
  localparam logic SEL2_RESULT = 1'b1;

  typedef struct packed {
    logic [1:0] sel1;
    logic [1:0] wa;
    logic       we;
    logic [1:0] raa;
    logic       rea;
    logic [1:0] rab;
    logic       reb;
    logic [1:0] c;
    logic       sel2;
    logic       done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{sel1: SEL1_HOLD, wa: R0, we: 1'b0, raa: R0, rea: 1'b0,
                                  rab: R0, reb: 1'b0, c: OP_ADD, sel2: SEL2_PASS, done: 1'b0};

endpackage

// File: rtl/fsm_cu_decode.sv
// Moore output decode: current state (plus Op in Execute) to control word.
// Purely combinational; C tracks Op with no register in between during Execute.
module fsm_cu_decode
  import fsm_cu_pkg::*;
(
  input  state_t     i_state,
  input  logic [1:0] i_op,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_IDLE;
    case (i_state)
      S_LOADA: begin
        o_ctrl.sel1 = SEL1_IN_A;
        o_ctrl.wa   = R1;
        o_ctrl.we   = 1'b1;
      end
      S_LOADB: begin
        o_ctrl.sel1 = SEL1_IN_B;
        o_ctrl.wa   = R2;
        o_ctrl.we   = 1'b1;
      end
      S_EXEC: begin
        // R3 <= R1 op R2
        o_ctrl.sel1 = SEL1_ALU;
        o_ctrl.wa   = R3;
        o_ctrl.we   = 1'b1;
        o_ctrl.raa  = R1;
        o_ctrl.rea  = 1'b1;
        o_ctrl.rab  = R2;
        o_ctrl.reb  = 1'b1;
        o_ctrl.c    = i_op;
      end
      S_DISP: begin
        o_ctrl.raa  = R3;
        o_ctrl.rea  = 1'b1;
        o_ctrl.rab  = R3;
        o_ctrl.reb  = 1'b1;
        o_ctrl.c    = OP_AND;
        o_ctrl.sel2 = SEL2_RESULT;
        o_ctrl.done = 1'b1;
      end
      default: o_ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/fsm_cu.sv
// Calculator control unit: Idle -> LoadA -> LoadB -> Execute -> Display -> Wait, Done 4 edges
// after Go; Wait holds until Go is released so one request yields exactly one result.
module fsm_cu
  import fsm_cu_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       Go,
  input  logic [1:0] Op,
  output logic [1:0] Sel1,
  output logic [1:0] WA,
  output logic       WE,
  output logic [1:0] RAA,
  output logic       REA,
  output logic [1:0] RAB,
  output logic       REB,
  output logic [1:0] C,
  output logic       Sel2,
  output logic       Done,
  output logic [2:0] CS
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge CLK) begin
    if (!RST_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = Go ? S_LOADA : S_IDLE;
      S_LOADA: w_next = S_LOADB;
      S_LOADB: w_next = S_EXEC;
      S_EXEC:  w_next = S_DISP;
      S_DISP:  w_next = S_WAIT;
      S_WAIT:  w_next = Go ? S_WAIT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  fsm_cu_decode u_decode (
    .i_state (r_state),
    .i_op    (Op),
    .o_ctrl  (w_ctrl)
  );

  assign Sel1 = w_ctrl.sel1;
  assign WA   = w_ctrl.wa;
  assign WE   = w_ctrl.we;
  assign RAA  = w_ctrl.raa;
  assign REA  = w_ctrl.rea;
  assign RAB  = w_ctrl.rab;
  assign REB  = w_ctrl.reb;
  assign C    = w_ctrl.c;
  assign Sel2 = w_ctrl.sel2;
  assign Done = w_ctrl.done;
  assign CS   = r_state;

endmodule

// File: tb/tb_fsm_cu.sv
// Directed bench for fsm_cu: stimulus pushes the expected per-cycle state and control word,
// a negedge monitor pops and compares against the DUT.
module tb_fsm_cu;

  logic       CLK = 1'b0;
  logic       RST_n, Go;
  logic [1:0] Op;
  logic [1:0] Sel1, WA, RAA, RAB, C;
  logic       WE, REA, REB, Sel2, Done;
  logic [2:0] CS;

  fsm_cu dut (
    .CLK(CLK), .RST_n(RST_n), .Go(Go), .Op(Op),
    .Sel1(Sel1), .WA(WA), .WE(WE), .RAA(RAA), .REA(REA),
    .RAB(RAB), .REB(REB), .C(C), .Sel2(Sel2), .Done(Done), .CS(CS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic [2:0]  cs;
    logic [14:0] word;
    int          id;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Hand-written control words, ordered {Sel1,WA,WE,RAA,REA,RAB,REB,C,Sel2,Done}.
  function automatic logic [14:0] exp_word(input logic [2:0] cs, input logic [1:0] op);
    case (cs)
      3'b001:  exp_word = {2'b11, 2'b01, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      3'b010:  exp_word = {2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
      3'b100:  exp_word = {2'b00, 2'b11, 1'b1, 2'b01, 1'b1, 2'b10, 1'b1, op,    1'b0, 1'b0};
      3'b101:  exp_word = {2'b01, 2'b00, 1'b0, 2'b11, 1'b1, 2'b11, 1'b1, 2'b10, 1'b1, 1'b1};
      default: exp_word = {2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0};
    endcase
  endfunction

  always @(negedge CLK) begin
    logic [14:0] act;
    exp_t        e;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e   = q.pop_front();
      act = {Sel1, WA, WE, RAA, REA, RAB, REB, C, Sel2, Done};
      n_total++;
      if (CS === e.cs) n_pass++;
      else $display("FAIL cs[%0d] cyc=%0d got=%b want=%b", e.id, cyc, CS, e.cs);
      n_total++;
      if (act === e.word) n_pass++;
      else $display("FAIL word[%0d] cyc=%0d got=%b want=%b", e.id, cyc, act, e.word);
    end
  end

  int id = 0;

  // Drive inputs for the current cycle; expectation describes the current state's outputs.
  task automatic step(input logic rst, input logic go, input logic [1:0] op,
                      input logic chk, input logic [2:0] cs);
    exp_t e;
    RST_n = rst;
    Go    = go;
    Op    = op;
    if (chk) begin
      e.cyc  = cyc;
      e.cs   = cs;
      e.word = exp_word(cs, op);
      e.id   = id;
      q.push_back(e);
      id++;
    end
    @(posedge CLK);
    #2;
  endtask

  localparam logic [2:0] IDLE = 3'b000, LA = 3'b001, LB = 3'b010;
  localparam logic [2:0] WT = 3'b011, EX = 3'b100, DP = 3'b101;

  initial begin
    // reset with Go high, then Idle hold
    step(1'b0, 1'b1, 2'b00, 1'b0, IDLE);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b00, 1'b1, IDLE);

    // one full sequence per Op, single-cycle Go pulse
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 2'(k), 1'b1, IDLE);
      step(1'b1, 1'b0, 2'(k), 1'b1, LA);
      step(1'b1, 1'b0, 2'(k), 1'b1, LB);
      step(1'b1, 1'b0, 2'(k), 1'b1, EX);
      step(1'b1, 1'b0, 2'(k), 1'b1, DP);
      step(1'b1, 1'b0, 2'(k), 1'b1, WT);
    end
    step(1'b1, 1'b0, 2'b00, 1'b1, IDLE);

    // Go held through the sequence: park in Wait until released
    step(1'b1, 1'b1, 2'b11, 1'b1, IDLE);
    step(1'b1, 1'b1, 2'b11, 1'b1, LA);
    step(1'b1, 1'b1, 2'b11, 1'b1, LB);
    step(1'b1, 1'b1, 2'b11, 1'b1, EX);
    step(1'b1, 1'b1, 2'b11, 1'b1, DP);
    step(1'b1, 1'b1, 2'b11, 1'b1, WT);
    step(1'b1, 1'b1, 2'b11, 1'b1, WT);
    step(1'b1, 1'b0, 2'b11, 1'b1, WT);
    step(1'b1, 1'b1, 2'b00, 1'b1, IDLE);
    step(1'b1, 1'b0, 2'b00, 1'b1, LA);
    step(1'b1, 1'b0, 2'b00, 1'b1, LB);
    step(1'b1, 1'b0, 2'b00, 1'b1, EX);
    step(1'b1, 1'b0, 2'b00, 1'b1, DP);
    step(1'b1, 1'b0, 2'b00, 1'b1, WT);

    // reset while in Execute aborts before Display
    step(1'b1, 1'b1, 2'b01, 1'b1, IDLE);
    step(1'b1, 1'b1, 2'b01, 1'b1, LA);
    step(1'b1, 1'b1, 2'b01, 1'b1, LB);
    step(1'b0, 1'b1, 2'b01, 1'b1, EX);
    step(1'b1, 1'b0, 2'b01, 1'b1, IDLE);
    step(1'b1, 1'b0, 2'b01, 1'b1, IDLE);

    // Op changes outside Execute are ignored; Execute shows the live Op
    step(1'b1, 1'b1, 2'b00, 1'b1, IDLE);
    step(1'b1, 1'b0, 2'b10, 1'b1, LA);
    step(1'b1, 1'b0, 2'b11, 1'b1, LB);
    step(1'b1, 1'b0, 2'b01, 1'b1, EX);
    step(1'b1, 1'b0, 2'b01, 1'b1, DP);
    step(1'b1, 1'b0, 2'b11, 1'b1, WT);
    step(1'b1, 1'b0, 2'b00, 1'b1, IDLE);

    @(negedge CLK);
    #1;
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
